button_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of `counter_top`. It takes the three raw, asynchronous, bouncing pushbutton pads (counter reset, start, stop) and produces clean one-cycle command pulses in the `clk` domain. It synchronises each pad, debounces it, detects press edges and resolves same-cycle conflicts. Its outputs drive `counter_top`'s `cnt_rst`, `cnt_start` and `cnt_stop` ports one-to-one.

---
 rtl/button_conditioner.sv | 73 +++++++
 tb/tb_button_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions three raw pushbutton pads into debounced levels and one-cycle,
// priority-arbitrated command pulses (rst > stop > start) in the clk domain.
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CNT_W     = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_rst_in,
    input  logic       btn_start_in,
    input  logic       btn_stop_in,
    output logic       cnt_rst,
    output logic       cnt_start,
    output logic       cnt_stop,
    output logic [2:0] btn_level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    // Channel order matches btn_level: [2]=rst, [1]=stop, [0]=start.
    logic [2:0] pad;
    logic [2:0] level;
    logic [2:0] rise;

    assign pad = {btn_rst_in, btn_stop_in, btn_start_in};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             lvl;
        logic [CNT_W-1:0] dbc;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                lvl <= 1'b0;
                dbc <= '0;
            end else begin
                s1 <= pad[g];
                s2 <= s1;
                if (s2 == lvl) begin
                    dbc <= '0;
                end else if (dbc == DB_LAST) begin
                    lvl <= s2;
                    dbc <= '0;
                end else begin
                    dbc <= dbc + CNT_W'(1);
                end
            end
        end

        // Rising level change is decoded one edge early so the pulse is
        // registered at the same edge the level itself updates.
        assign rise[g]  = s2 && !lvl && (dbc == DB_LAST);
        assign level[g] = lvl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_rst   <= 1'b0;
            cnt_stop  <= 1'b0;
            cnt_start <= 1'b0;
        end else begin
            cnt_rst   <= rise[2];
            cnt_stop  <= rise[1] && !rise[2];
            cnt_start <= rise[0] && !rise[1] && !rise[2];
        end
    end

    assign btn_level = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// pad activity, checked every cycle against a sliding-window reference model.
module tb_button_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_rst_in = 1'b1;
    logic       btn_start_in = 1'b1;
    logic       btn_stop_in = 1'b1;
    logic       cnt_rst;
    logic       cnt_start;
    logic       cnt_stop;
    logic [2:0] btn_level;

    int checks   = 0;
    int failures = 0;
    int n_rst    = 0;
    int n_stop   = 0;
    int n_start  = 0;

    button_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_rst_in   (btn_rst_in),
        .btn_start_in (btn_start_in),
        .btn_stop_in  (btn_stop_in),
        .cnt_rst      (cnt_rst),
        .cnt_start    (cnt_start),
        .cnt_stop     (cnt_stop),
        .btn_level    (btn_level)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the last DB synchronised samples
    // (all taken since the last reset) every one differ from it.
    logic [2:0] m_d1 = '0;
    logic [2:0] m_d2 = '0;
    logic [2:0] m_level = '0;
    logic [2:0] m_rise = '0;
    logic [2:0] hist[$];
    logic       m_rst = 1'b0;
    logic       m_stop = 1'b0;
    logic       m_start = 1'b0;

    always @(posedge clk) begin
        bit all_diff;
        if (rst) begin
            m_d1 = '0;
            m_d2 = '0;
            m_level = '0;
            hist.delete();
            m_rst = 1'b0;
            m_stop = 1'b0;
            m_start = 1'b0;
        end else begin
            hist.push_back(m_d2);
            if (hist.size() > DB) void'(hist.pop_front());
            m_rise = '0;
            for (int i = 0; i < 3; i++) begin
                all_diff = (hist.size() == DB);
                foreach (hist[k]) if (hist[k][i] == m_level[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    m_rise[i]  = m_level[i];
                end
            end
            m_rst   = m_rise[2];
            m_stop  = m_rise[1] && !m_rise[2];
            m_start = m_rise[0] && !m_rise[1] && !m_rise[2];
            m_d2 = m_d1;
            m_d1 = {btn_rst_in, btn_stop_in, btn_start_in};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_rst === 1'b1) n_rst++;
        if (cnt_stop === 1'b1) n_stop++;
        if (cnt_start === 1'b1) n_start++;
        check("model_cnt_rst", 32'(cnt_rst), 32'(m_rst));
        check("model_cnt_stop", 32'(cnt_stop), 32'(m_stop));
        check("model_cnt_start", 32'(cnt_start), 32'(m_start));
        check("model_btn_level", 32'(btn_level), 32'(m_level));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pads(input logic r, input logic sp, input logic st);
        btn_rst_in   = r;
        btn_stop_in  = sp;
        btn_start_in = st;
    endtask

    task automatic clear_counts();
        n_rst = 0;
        n_stop = 0;
        n_start = 0;
    endtask

    initial begin
        // Reset with all pads held high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs_zero", {28'd0, cnt_rst, cnt_stop, cnt_start, 1'b0}, 32'd0);
            check("rst_level_zero", 32'(btn_level), 32'd0);
        end
        rst = 1'b0;
        clear_counts();
        ticks(5);
        check("rst_pulse_early", 32'(n_rst), 32'd0);
        tick();
        check("rst_pulse_at_6", 32'(cnt_rst), 32'd1);
        check("rst_stop_dropped", 32'(cnt_stop), 32'd0);
        check("rst_start_dropped", 32'(cnt_start), 32'd0);
        ticks(10);
        check("rst_single_pulse", 32'(n_rst), 32'd1);
        check("rst_no_stop", 32'(n_stop), 32'd0);
        check("rst_no_start", 32'(n_start), 32'd0);
        pads(0, 0, 0);
        ticks(10);
        check("release_levels", 32'(btn_level), 32'd0);

        // Clean press of start
        clear_counts();
        pads(0, 0, 1);
        ticks(5);
        check("press_early", 32'(n_start), 32'd0);
        tick();
        check("press_pulse_at_6", 32'(cnt_start), 32'd1);
        check("press_level", 32'(btn_level[0]), 32'd1);
        ticks(20);
        check("press_held_once", 32'(n_start), 32'd1);
        pads(0, 0, 0);
        ticks(10);

        // Bouncing stop pad
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            pads(0, 1, 0); ticks(2);
            pads(0, 0, 0); ticks(2);
        end
        check("bounce_no_pulse", 32'(n_stop), 32'd0);
        pads(0, 1, 0);
        ticks(5);
        check("bounce_early", 32'(n_stop), 32'd0);
        tick();
        check("bounce_pulse_at_6", 32'(cnt_stop), 32'd1);
        ticks(10);
        check("bounce_single", 32'(n_stop), 32'd1);
        pads(0, 0, 0);
        ticks(10);

        // Short release filtered, long release re-arms
        clear_counts();
        pads(0, 0, 1); ticks(10);
        pads(0, 0, 0); ticks(3);
        pads(0, 0, 1); ticks(12);
        check("short_release_filtered", 32'(n_start), 32'd1);
        pads(0, 0, 0); ticks(6);
        pads(0, 0, 1); ticks(12);
        check("long_release_repress", 32'(n_start), 32'd2);
        pads(0, 0, 0);
        ticks(10);

        // Simultaneous presses
        clear_counts();
        pads(0, 1, 1); ticks(12);
        check("simul_stop_wins", 32'(n_stop), 32'd1);
        check("simul_start_dropped", 32'(n_start), 32'd0);
        pads(0, 0, 0); ticks(10);
        clear_counts();
        pads(1, 1, 1); ticks(12);
        check("simul3_rst_wins", 32'(n_rst), 32'd1);
        check("simul3_stop_dropped", 32'(n_stop), 32'd0);
        check("simul3_start_dropped", 32'(n_start), 32'd0);
        pads(0, 0, 0); ticks(10);

        // Reset in the middle of a debounce
        clear_counts();
        pads(0, 0, 1); ticks(3);
        rst = 1'b1; tick();
        rst = 1'b0;
        ticks(5);
        check("midrst_deadline_suppressed", 32'(n_start), 32'd0);
        tick();
        check("midrst_pulse_at_6", 32'(cnt_start), 32'd1);
        ticks(5);
        check("midrst_single", 32'(n_start), 32'd1);
        pads(0, 0, 0); ticks(10);

        // Random pad activity with occasional reset
        for (int s = 0; s < 150; s++) begin
            pads(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 19) == 0);
            ticks(int'($urandom_range(1, 10)));
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
